// File: rtl/memory_stage.sv
// memory_stage: Y86-64 memory stage with an internal 64-bit word data memory.
// Latency: done 1 cycle after acceptance for non-memory or faulted ops, MEM_LAT+1 cycles for memory ops.
// Backpressure: start is ignored while busy (ACCESS); a new op may be accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              request pulse, accepted when not busy
//   icode              Y86-64 instruction code
//   valE, valA, valP   execute result / register data / return address
//   inst_err           upstream invalid-instruction or imem error
//   busy               high while a memory access is in flight
//   done               one-cycle completion pulse
//   valM, stat         read data and status, updated on completion and held
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   -> aligned addresses beyond the memory raise ADR and perform no access
//   undefined -> the word index wraps modulo DMEM_WORDS
module memory_stage #(
  parameter int DMEM_WORDS = 1024,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        inst_err,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic [1:0]  stat
);

  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ST_AOK = 2'b00,
    ST_HLT = 2'b01,
    ST_ADR = 2'b10,
    ST_INS = 2'b11
  } stat_t;

  // Decoded operation captured at acceptance. Capturing the decoded form is
  // equivalent to latching the raw inputs: nothing else about them is used later.
  typedef struct packed {
    logic          is_rd;
    logic          is_wr;
    logic [AW-1:0] idx;
    logic [63:0]   wdat;
  } op_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  op_t         op_q;
  stat_t       stat_q;
  logic [63:0] valm_q;

  logic [63:0] mem [DMEM_WORDS];

  // Decode of the live inputs (only meaningful in the acceptance cycle).
  logic        dec_rd;
  logic        dec_wr;
  logic [63:0] dec_addr;
  logic [60:0] dec_word;
  logic        dec_oob;
  stat_t       dec_stat;
  logic        dec_go;
  op_t         dec_op;

  always_comb begin
    dec_rd = 1'b0;
    dec_wr = 1'b0;
    case (icode)
      I_MRMOVQ, I_RET, I_POPQ:   dec_rd = 1'b1;
      I_RMMOVQ, I_CALL, I_PUSHQ: dec_wr = 1'b1;
      default: ;
    endcase

    // ret/popq address through the stack pointer in valA, everything else via valE.
    dec_addr = (icode == I_RET || icode == I_POPQ) ? valA : valE;
    dec_word = dec_addr[63:3];

`ifdef DMEM_BOUNDS_CHECK_EN
    dec_oob = (dec_word >= 61'(DMEM_WORDS));
`else
    dec_oob = 1'b0;
`endif

    if (inst_err || icode > I_POPQ) begin
      dec_stat = ST_INS;
    end else if ((dec_rd || dec_wr) && (dec_addr[2:0] != 3'b000 || dec_oob)) begin
      dec_stat = ST_ADR;
    end else if (icode == I_HALT) begin
      dec_stat = ST_HLT;
    end else begin
      dec_stat = ST_AOK;
    end

    // Only clean memory ops enter ACCESS; faults complete immediately with no access.
    dec_go = (dec_rd || dec_wr) && (dec_stat == ST_AOK);

    dec_op.is_rd = dec_rd;
    dec_op.is_wr = dec_wr;
    dec_op.idx   = AW'(dec_word % 61'(DMEM_WORDS));
    dec_op.wdat  = (icode == I_CALL) ? valP : valA;
  end

  // Next-state logic.
  logic accept;
  logic commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept = 1'b1;
          if (dec_go) begin
            state_d = S_ACCESS;
            cnt_d   = LAT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        // Leave when the counter hits zero on this edge, so the op spends
        // exactly MEM_LAT cycles in ACCESS and done lands MEM_LAT+1 after acceptance.
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= '0;
      stat_q  <= ST_AOK;
      valm_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= dec_op;
        // Ops that skip ACCESS enter DONE on this same edge, so publish now.
        if (!dec_go) begin
          stat_q <= dec_stat;
          valm_q <= 64'd0;
        end
      end
      if (commit) begin
        stat_q <= ST_AOK;
        valm_q <= op_q.is_rd ? mem[op_q.idx] : 64'd0;
      end
    end
  end

  // Writes land only on the edge entering DONE; a reset in ACCESS drops them.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_q.is_wr) begin
      mem[op_q.idx] <= op_q.wdat;
    end
  end

  assign busy = (state_q == S_ACCESS);
  assign done = (state_q == S_DONE);
  assign valM = valm_q;
  assign stat = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage.
// Stimulus pushes the reference-model response; an independent monitor pops on done.
module tb_memory_stage;

  localparam int DMEM_WORDS = 1024;
  localparam int MEM_LAT    = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        inst_err;
  logic        busy, done;
  logic [63:0] valM;
  logic [1:0]  stat;

  memory_stage #(.DMEM_WORDS(DMEM_WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP), .inst_err(inst_err),
    .busy(busy), .done(done), .valM(valM), .stat(stat)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] vm;
    longint      when;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] ref_mem [DMEM_WORDS];
  logic [3:0]  mem_codes [6] = '{4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  int          errors = 0;
  int          checks = 0;
  int          n_ops  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: architectural rules applied directly to an array.
  task automatic expect_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                           input logic [63:0] p, input logic err);
    exp_t            x;
    int              lat;
    logic [63:0]     addr, wd;
    longint unsigned word;
    int              widx;
    bit              rd, wr, bad;
    rd   = (ic == 5 || ic == 9 || ic == 11);
    wr   = (ic == 4 || ic == 8 || ic == 10);
    addr = (ic == 9 || ic == 11) ? a : e;
    wd   = (ic == 8) ? p : a;
    word = addr / 8;
    widx = int'(word % 64'(DMEM_WORDS));
    bad  = (rd || wr) && ((addr % 8) != 0 || (BOUNDS && word >= 64'(DMEM_WORDS)));
    if (err || ic > 11)      x.st = 2'b11;
    else if (bad)            x.st = 2'b10;
    else if (ic == 0)        x.st = 2'b01;
    else                     x.st = 2'b00;
    x.vm = 64'd0;
    lat  = 1;
    if (x.st == 2'b00 && (rd || wr)) begin
      lat = MEM_LAT + 1;
      if (wr) ref_mem[widx] = wd;
      else    x.vm = ref_mem[widx];
    end
    x.when = cyc + longint'(lat);
    x.id   = n_ops;
    n_ops++;
    sbq.push_back(x);
  endtask

  task automatic scramble();
    icode    = 4'($urandom);
    valE     = {$urandom, $urandom};
    valA     = {$urandom, $urandom};
    valP     = {$urandom, $urandom};
    inst_err = 1'($urandom);
  endtask

  // Called at a negedge; returns one negedge later with start dropped.
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic err);
    expect_op(ic, e, a, p, err);
    icode = ic; valE = e; valA = a; valP = p; inst_err = err;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected done=1", name, n);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] w;
    w = 64'($urandom_range(0, 39));
    case ($urandom_range(0, 3))
      0, 1:    return w * 8;
      2:       return w * 8 + 64'($urandom_range(1, 7));
      default: return (64'($urandom_range(1, 65535)) << 13) | (w * 8);
    endcase
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk($sformatf("op%0d_stat", mon_e.id), 64'(stat), 64'(mon_e.st));
        chk($sformatf("op%0d_valM", mon_e.id), valM, mon_e.vm);
        chk($sformatf("op%0d_cycle", mon_e.id), 64'(cyc), 64'(mon_e.when));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [63:0] saved;
  logic [3:0]  ric;
  logic [63:0] w0;

  initial begin
    reset = 1'b1; start = 1'b0; icode = 4'd0;
    valE = 64'd0; valA = 64'd0; valP = 64'd0; inst_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valM", valM, 64'd0);
    chk("reset_stat", 64'(stat), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Give every word the bench will touch a known value.
    for (int w = 0; w < 40; w++) begin
      issue(4'd4, 64'(w * 8), {$urandom, $urandom}, 64'd0, 1'b0);
      wait_done("preload");
    end
    @(negedge clk);

    issue(4'd4, 64'h40, 64'hDEADBEEF, 64'd0, 1'b0);
    wait_done("rmmovq");
    @(negedge clk);
    issue(4'd5, 64'h40, 64'd0, 64'd0, 1'b0);
    wait_done("mrmovq");
    chk("mrmovq_valM", valM, 64'hDEADBEEF);
    @(negedge clk);

    issue(4'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    wait_done("halt");
    chk("halt_stat", 64'(stat), 64'd1);
    issue(4'd6, 64'd5, 64'd7, 64'd0, 1'b0);
    wait_done("opq");
    chk("opq_stat", 64'(stat), 64'd0);
    @(negedge clk);

    issue(4'd10, 64'h43, 64'h1111, 64'd0, 1'b0);
    wait_done("push_misaligned");
    chk("push_misaligned_stat", 64'(stat), 64'd2);
    @(negedge clk);
    issue(4'd5, 64'h40, 64'd0, 64'd0, 1'b0);
    wait_done("readback40");
    chk("readback40_valM", valM, 64'hDEADBEEF);
    @(negedge clk);

    w0 = ref_mem[0];
    issue(4'd5, 64'(8 * DMEM_WORDS), 64'd0, 64'd0, 1'b0);
    wait_done("oob");
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("oob_stat", 64'(stat), 64'd2);
`else
    chk("oob_wrap_valM", valM, w0);
`endif
    @(negedge clk);

    // Reset during ACCESS aborts the write.
    saved = ref_mem[16];
    icode = 4'd4; valE = 64'h80; valA = 64'hBAD0_BAD0_BAD0_BAD0; valP = 64'd0; inst_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_in_access", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_valM", valM, 64'd0);
    chk("abort_stat", 64'(stat), 64'd0);
    repeat (4) @(negedge clk);
    issue(4'd5, 64'h80, 64'd0, 64'd0, 1'b0);
    wait_done("abort_readback");
    chk("abort_word80", valM, saved);
    @(negedge clk);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; icode = 4'd1; inst_err = 1'b0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_over_start_done", 64'(done), 64'd0);
    chk("reset_over_start_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // start held through ACCESS with changing inputs is ignored.
    expect_op(4'd4, 64'h88, 64'hA5A5_0000_1111_2222, 64'd0, 1'b0);
    icode = 4'd4; valE = 64'h88; valA = 64'hA5A5_0000_1111_2222; valP = 64'd0; inst_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    valE = 64'h90; valA = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("held_busy", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("held_done", 64'(done), 64'd1);
    start = 1'b0;
    scramble();
    @(negedge clk);
    chk("held_idle", 64'(done), 64'd0);
    issue(4'd5, 64'h90, 64'd0, 64'd0, 1'b0);
    wait_done("held_read90");
    @(negedge clk);
    issue(4'd5, 64'h88, 64'd0, 64'd0, 1'b0);
    wait_done("held_read88");
    chk("held_read88_valM", valM, 64'hA5A5_0000_1111_2222);
    @(negedge clk);

    // call then ret issued in the call's DONE cycle.
    issue(4'd8, 64'h100, 64'd0, 64'h1234, 1'b0);
    wait_done("call");
    issue(4'd9, 64'd0, 64'h100, 64'd0, 1'b0);
    wait_done("ret");
    chk("ret_valM", valM, 64'h1234);
    @(negedge clk);

    // Random traffic, mixing back-to-back and gapped issue.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) ric = 4'($urandom_range(0, 15));
      else                           ric = mem_codes[$urandom_range(0, 5)];
      issue(ric, rand_addr(), ($urandom_range(0, 1) == 1) ? rand_addr() : {$urandom, $urandom},
            {$urandom, $urandom}, ($urandom_range(0, 15) == 0));
      wait_done("rand");
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
